// File: rtl/branch_resolve_predict.sv
// Branch resolution and 2-bit saturating-counter prediction for the multicycle
// MIPS datapath. Decodes six branch conditions from the ALU flags, drives the
// PC write enable, trains a direct-mapped counter table, flags mispredictions
// and keeps saturating branch/mispredict statistics.
module branch_resolve_predict #(
    parameter int         PC_WIDTH   = 32,
    parameter int         INDEX_BITS = 4,
    parameter logic [1:0] CNT_INIT   = 2'b01,
    parameter int         STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Pred_Req,
    input  logic [PC_WIDTH-1:0]   Pred_PC,
    output logic                  Pred_Taken,
    output logic                  Pred_Valid,
    input  logic                  Res_Valid,
    input  logic [PC_WIDTH-1:0]   Res_PC,
    input  logic [2:0]            Cond,
    input  logic                  Zero,
    input  logic                  Negative,
    input  logic                  Pred_Was_Taken,
    input  logic                  PCWrite,
    output logic                  Branch,
    output logic                  PC_En,
    output logic                  Mispredict,
    output logic [STAT_WIDTH-1:0] Branch_Count,
    output logic [STAT_WIDTH-1:0] Mispredict_Count
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    // Counter saturates at strongly taken.
    function automatic logic [1:0] ctr_inc(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'b01;
    endfunction

    // Counter saturates at strongly not-taken.
    function automatic logic [1:0] ctr_dec(input logic [1:0] v);
        return (v == 2'b00) ? v : v - 2'b01;
    endfunction

    // Statistics stick at all-ones instead of wrapping.
    function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + STAT_WIDTH'(1);
    endfunction

    logic                  cond_true;
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] res_idx;
    logic [1:0]            pht [ENTRIES];
    logic                  unused_pc_bits;

    // Word-aligned PCs: bits [1:0] carry no information, upper bits alias.
    assign pred_idx = Pred_PC[INDEX_BITS+1:2];
    assign res_idx  = Res_PC[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{Pred_PC[PC_WIDTH-1:INDEX_BITS+2], Pred_PC[1:0],
                              Res_PC[PC_WIDTH-1:INDEX_BITS+2], Res_PC[1:0]};

    // Condition decode from ALU flags; codes 6 and 7 are never taken.
    always_comb begin
        cond_true = 1'b0;
        case (Cond)
            3'd0:    cond_true = Zero;
            3'd1:    cond_true = ~Zero;
            3'd2:    cond_true = Zero | Negative;
            3'd3:    cond_true = ~Zero & ~Negative;
            3'd4:    cond_true = Negative;
            3'd5:    cond_true = ~Negative;
            default: cond_true = 1'b0;
        endcase
    end

    assign Branch = Res_Valid & cond_true;
    assign PC_En  = PCWrite | Branch;

    // Predictor table training on each resolution.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= CNT_INIT;
            end
        end else if (Res_Valid) begin
            pht[res_idx] <= cond_true ? ctr_inc(pht[res_idx]) : ctr_dec(pht[res_idx]);
        end
    end

    // Prediction lookup; reads the pre-update counter when colliding with a resolution.
    always_ff @(posedge clk) begin
        if (reset) begin
            Pred_Taken <= 1'b0;
            Pred_Valid <= 1'b0;
        end else begin
            Pred_Valid <= Pred_Req;
            if (Pred_Req) begin
                Pred_Taken <= pht[pred_idx][1];
            end
        end
    end

    // Mispredict pulse and saturating statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            Mispredict       <= 1'b0;
            Branch_Count     <= '0;
            Mispredict_Count <= '0;
        end else begin
            Mispredict <= Res_Valid & (cond_true != Pred_Was_Taken);
            if (Res_Valid) begin
                Branch_Count <= stat_inc(Branch_Count);
            end
            if (Mispredict) begin
                Mispredict_Count <= stat_inc(Mispredict_Count);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Scoreboard bench for branch_resolve_predict (INDEX_BITS = 4, STAT_WIDTH = 4).
module tb_branch_resolve_predict;

    localparam int PW = 32;
    localparam int IB = 4;
    localparam int SW = 4;
    localparam int SAT = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          Pred_Req;
    logic [PW-1:0] Pred_PC;
    logic          Pred_Taken;
    logic          Pred_Valid;
    logic          Res_Valid;
    logic [PW-1:0] Res_PC;
    logic [2:0]    Cond;
    logic          Zero;
    logic          Negative;
    logic          Pred_Was_Taken;
    logic          PCWrite;
    logic          Branch;
    logic          PC_En;
    logic          Mispredict;
    logic [SW-1:0] Branch_Count;
    logic [SW-1:0] Mispredict_Count;

    always #5 clk = ~clk;

    branch_resolve_predict #(
        .PC_WIDTH(PW), .INDEX_BITS(IB), .CNT_INIT(2'b01), .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .reset(reset),
        .Pred_Req(Pred_Req), .Pred_PC(Pred_PC),
        .Pred_Taken(Pred_Taken), .Pred_Valid(Pred_Valid),
        .Res_Valid(Res_Valid), .Res_PC(Res_PC), .Cond(Cond),
        .Zero(Zero), .Negative(Negative), .Pred_Was_Taken(Pred_Was_Taken),
        .PCWrite(PCWrite), .Branch(Branch), .PC_En(PC_En),
        .Mispredict(Mispredict), .Branch_Count(Branch_Count),
        .Mispredict_Count(Mispredict_Count)
    );

    typedef struct {
        logic val;
        int   due;
    } exp_t;

    exp_t pq[$];
    exp_t mq[$];
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [1:0] m_pht [1 << IB];
    int         m_bc;
    int         m_mc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic model_cond(input logic [2:0] c, input logic z, input logic n);
        case (c)
            3'd0:    return z;
            3'd1:    return !z;
            3'd2:    return z || n;
            3'd3:    return !z && !n;
            3'd4:    return n;
            3'd5:    return !n;
            default: return 1'b0;
        endcase
    endfunction

    // Output monitor: pops scoreboard entries when they fall due.
    always @(negedge clk) begin
        if (mon_en) begin
            if (pq.size() > 0 && pq[0].due == cyc) begin
                check("pred_valid", Pred_Valid, 1);
                check("pred_taken", Pred_Taken, pq[0].val);
                void'(pq.pop_front());
            end else begin
                check("pred_valid_idle", Pred_Valid, 0);
            end
            if (mq.size() > 0 && mq[0].due == cyc) begin
                check("mispredict", Mispredict, mq[0].val);
                void'(mq.pop_front());
            end else begin
                check("mispredict_idle", Mispredict, 0);
            end
        end
    end

    task automatic drive(input logic rst_i, input logic req, input logic [31:0] ppc,
                         input logic res, input logic [31:0] rpc, input logic [2:0] cnd,
                         input logic z, input logic n, input logic pwt, input logic pcw);
        logic ct;
        exp_t e;
        int   pi;
        int   ri;
        @(posedge clk);
        #1;
        reset = rst_i; Pred_Req = req; Pred_PC = ppc; Res_Valid = res; Res_PC = rpc;
        Cond = cnd; Zero = z; Negative = n; Pred_Was_Taken = pwt; PCWrite = pcw;
        #1;
        ct = model_cond(cnd, z, n);
        check("branch", Branch, res & ct);
        check("pc_en", PC_En, pcw | (res & ct));
        pi = int'(ppc[IB+1:2]);
        ri = int'(rpc[IB+1:2]);
        if (rst_i) begin
            for (int i = 0; i < (1 << IB); i++) m_pht[i] = 2'b01;
            m_bc = 0;
            m_mc = 0;
        end else begin
            if (req) begin
                e.val = m_pht[pi][1];
                e.due = cyc + 1;
                pq.push_back(e);
            end
            if (res) begin
                e.val = (ct != pwt);
                e.due = cyc + 1;
                mq.push_back(e);
                if (ct) m_pht[ri] = (m_pht[ri] == 2'b11) ? 2'b11 : m_pht[ri] + 2'b01;
                else    m_pht[ri] = (m_pht[ri] == 2'b00) ? 2'b00 : m_pht[ri] - 2'b01;
                if (m_bc < SAT) m_bc++;
                if (ct != pwt && m_mc < SAT) m_mc++;
            end
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        drive(0, 1, pc, 0, 0, 3'd0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [2:0] c, input logic z,
                           input logic n, input logic pwt);
        drive(0, 0, 0, 1, pc, c, z, n, pwt, 0);
    endtask

    task automatic check_stats();
        idle();
        idle();
        check("branch_count", Branch_Count, m_bc);
        check("mispredict_count", Mispredict_Count, m_mc);
    endtask

    task automatic do_reset();
        drive(1, 1, 32'h40, 0, 0, 3'd0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        mon_en = 1'b1;
        check("rst_pred_taken", Pred_Taken, 0);
        check("rst_pred_valid", Pred_Valid, 0);
        check("rst_mispredict", Mispredict, 0);
        check("rst_branch_count", Branch_Count, 0);
        check("rst_mispredict_count", Mispredict_Count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; Pred_Req = 0; Pred_PC = 0; Res_Valid = 0; Res_PC = 0;
        Cond = 0; Zero = 0; Negative = 0; Pred_Was_Taken = 0; PCWrite = 0;
        for (int i = 0; i < (1 << IB); i++) m_pht[i] = 2'b01;
        m_bc = 0;
        m_mc = 0;

        do_reset();
        lookup(32'h40);

        // Counter training at 0x40: up to saturation, then back down.
        resolve(32'h40, 3'd0, 1, 0, 0);
        lookup(32'h40);
        resolve(32'h40, 3'd0, 1, 0, 1);
        resolve(32'h40, 3'd0, 1, 0, 1);
        lookup(32'h40);
        resolve(32'h40, 3'd0, 0, 0, 1);
        lookup(32'h40);
        resolve(32'h40, 3'd0, 0, 0, 1);
        lookup(32'h40);
        check_stats();

        // Aliasing: 0x80 shares index 0, 0x44 is index 1.
        resolve(32'h40, 3'd0, 1, 0, 0);
        lookup(32'h80);
        lookup(32'h44);

        // Read-before-write on the same index.
        drive(0, 1, 32'h48, 1, 32'h48, 3'd0, 1, 0, 0, 0);
        lookup(32'h48);
        idle();

        // Mispredict pulse and count.
        do_reset();
        resolve(32'h50, 3'd0, 1, 0, 0);
        check_stats();

        // Resolution coinciding with reset is dropped.
        drive(1, 0, 0, 1, 32'h60, 3'd0, 1, 0, 0, 0);
        check_stats();

        // 17 resolutions saturate the 4-bit branch counter.
        for (int i = 0; i < 17; i++) resolve(32'h3C, 3'd1, 0, 0, 1);
        check_stats();

        // Full condition decode sweep with Res_Valid = 1.
        for (int c = 0; c < 8; c++)
            for (int z = 0; z < 2; z++)
                for (int n = 0; n < 2; n++)
                    drive(0, 0, 0, 1, 32'h3C, 3'(c), 1'(z), 1'(n), 0, 0);
        // With Res_Valid = 0, Branch stays low and PC_En follows PCWrite.
        for (int c = 0; c < 8; c++)
            for (int p = 0; p < 2; p++)
                drive(0, 0, 0, 0, 32'h3C, 3'(c), 1, 1, 0, 1'(p));
        lookup(32'h3C);
        check_stats();

        idle();
        idle();
        check("pred_queue_drained", pq.size(), 0);
        check("misp_queue_drained", mq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_predict.md
# branch_resolve_predict

Parametrised branch resolution and prediction unit for the multicycle MIPS datapath. It evaluates six branch conditions (BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ) from the ALU Zero and Negative flags and drives the PC-write enable. It keeps a direct-mapped table of 2-bit saturating counters for branch prediction, flags mispredictions, and maintains saturating statistics counters. It sits between the control FSM, the ALU flags and the PC register.

## Interface
Parameters:
- PC_WIDTH, 32: width of the PC inputs.
- INDEX_BITS, 4: table index width; ENTRIES = 2^INDEX_BITS.
- CNT_INIT, 2'b01: reset value of every predictor counter (weakly not-taken).
- STAT_WIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Pred_Req  in  1  prediction lookup request.
- Pred_PC  in  PC_WIDTH  address of the branch to predict.
- Pred_Taken  out  1  registered prediction.
- Pred_Valid  out  1  one-cycle pulse marking a new Pred_Taken.
- Res_Valid  in  1  the branch is resolved this cycle (FSM branch-complete state).
- Res_PC  in  PC_WIDTH  address of the resolving branch.
- Cond  in  3  condition code: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ; codes 6 and 7 are never taken.
- Zero  in  1  ALU zero flag.
- Negative  in  1  ALU result sign bit.
- Pred_Was_Taken  in  1  the prediction that was used for this branch.
- PCWrite  in  1  unconditional PC write from the FSM.
- Branch  out  1  combinational branch-taken signal.
- PC_En  out  1  combinational PC write enable.
- Mispredict  out  1  registered one-cycle pulse.
- Branch_Count  out  STAT_WIDTH  number of resolved branches.
- Mispredict_Count  out  STAT_WIDTH  number of mispredictions.

## Operation
- Condition decode: the condition value `cond_true` is selected by Cond:
  - BEQ: Zero
  - BNE: ~Zero
  - BLEZ: Zero | Negative
  - BGTZ: ~Zero & ~Negative
  - BLTZ: Negative
  - BGEZ: ~Negative
- Branch and PC enable:
  - Branch = Res_Valid & cond_true.
  - PC_En = PCWrite | Branch.
- Table index: idx = PC[INDEX_BITS+1:2]. The word-aligned bits [1:0] are ignored.
- Prediction: on Pred_Req, the unit registers Pred_Taken = table[idx(Pred_PC)][1] and pulses Pred_Valid. Without Pred_Req, Pred_Taken holds its value and Pred_Valid = 0.
- Update: on Res_Valid, table[idx(Res_PC)] changes as follows:
  - Taken (cond_true = 1): the counter increments, saturating at 2'b11.
  - Not taken: the counter decrements, saturating at 2'b00.
  - Codes 6 and 7 are treated as not taken and still update the table.
- Mispredict: registered as Res_Valid & (cond_true != Pred_Was_Taken).
- Statistics counters:
  - Branch_Count increments on every Res_Valid.
  - Mispredict_Count increments with every Mispredict set.
  - Both saturate at all-ones and never wrap.
- Simultaneous events:
  - Pred_Req and Res_Valid to the same index in the same cycle: the prediction returns the pre-update counter (read-before-write). The update is still applied.
  - Different indices: both operations proceed independently.
- Reset:
  - All table entries are set to CNT_INIT.
  - Pred_Taken = 0, Pred_Valid = 0, Mispredict = 0, both statistics counters = 0.
  - Reset takes priority over Pred_Req and Res_Valid in the same cycle; no update or lookup occurs.
- Reset mid-operation: a resolution in flight during reset is discarded, and no Mispredict pulse follows.

## Timing
- Branch and PC_En have zero latency; they are combinational from Res_Valid, Cond, Zero, Negative and PCWrite.
- Pred_Taken and Pred_Valid appear 1 cycle after Pred_Req.
- Mispredict appears 1 cycle after Res_Valid.
- A table update is visible to a Pred_Req issued in the cycle after Res_Valid.
- Mispredict_Count reflects a misprediction 2 cycles after its Res_Valid.
- Branch_Count reflects a resolution 1 cycle after its Res_Valid.
- There is no handshake back-pressure. One lookup and one resolution per cycle are accepted at most.

## Test plan
- Reset then lookup: assert reset, then Pred_Req with Pred_PC = 0x40. Required: Pred_Taken = 0 and Pred_Valid = 1 one cycle later; all outputs are 0 during reset.
- Condition decode: sweep Cond 0..7 × {Zero, Negative} with Res_Valid = 1 and PCWrite = 0. Required: Branch matches the decode rules above; for example, BGTZ with Zero = 0, Negative = 0 gives Branch = 1, and Cond = 7 gives Branch = 0. With Res_Valid = 0, Branch = 0 and PC_En = PCWrite.
- Counter training: resolve taken BEQ at PC 0x40 three times. Required: the counter goes 01→10→11→11, and Pred_Taken = 1 after the first update. Then resolve not-taken twice: counter 11→10→01, and Pred_Taken = 0.
- Aliasing and index: train PC 0x40 taken, then look up 0x80 (INDEX_BITS = 4). Required: 0x80 shares index 0 and returns taken; 0x44 (index 1) returns not-taken.
- Read-before-write: with the counter at 01, issue Pred_Req and a taken Res_Valid at the same PC in the same cycle. Required: Pred_Taken = 0; the next lookup returns 1.
- Mispredict and saturation: resolve taken with Pred_Was_Taken = 0. Required: Mispredict pulses 1 cycle later and Mispredict_Count = 1. With STAT_WIDTH = 4, 17 resolutions leave Branch_Count = 15.
